// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle between a sequencing controller and the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first, one operand bit per clock.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last sum/carry
// ADD   | shifting operand bits through the slice (busy)
// DONE  | result valid for this cycle (done); start here chains a new add
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  // One bit per state so busy/done come straight off a flop.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic             c;

  logic             half_s;
  logic             s;
  logic             c_next;
  logic             accept;
  logic             last;

  // Full adder built from two half-adder stages; the OR merges their carries.
  assign half_s  = sa[0] ^ sb[0];
  assign s       = half_s ^ c;
  assign c_next  = (sa[0] & sb[0]) | (half_s & c);

  // New bit enters at the MSB; written as a shift of {s, sr} so WIDTH=1 needs no special case.
  assign sr_next = WIDTH'({s, sr} >> 1);

  assign accept  = bus.start && ((state == IDLE) || (state == DONE));
  assign last    = (state == ADD) && (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only looked at in IDLE and DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ADD;
      ADD:     if (last)      state_next = DONE;
      DONE:    state_next = bus.start ? ADD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state flops only.
  always_comb begin
    bus.busy = (state == ADD);
    bus.done = (state == DONE);
  end

  // Operand capture, per-bit shift, and result load on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa        <= '0;
      sb        <= '0;
      sr        <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      bus.sum   <= '0;
      bus.carry <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      c   <= 1'b0;
      cnt <= '0;
    end else if (state == ADD) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      c   <= c_next;
      sr  <= sr_next;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.sum   <= sr_next;
        bus.carry <= c_next;
      end
    end
  end

endmodule
